xlink_rx_token_buffer: RTL and testbench

Receive-side token buffer between the XLINK token receiver and the link data processor. Captures 9-bit tokens strobed from the receiver, discards control tokens (bit 8 set), and stores data tokens in a circular FIFO. Presents the FIFO through a pop/empty interface: `rx_buf_dout` is valid the cycle after `rx_buf_en`, which is the contract the data processor relies on. Reports overflow and dropped-control-token statistics for debug registers.

---
 rtl/xlink_rx_token_buffer_if.sv | 25 ++
 rtl/xlink_rx_token_buffer.sv | 90 +++++++++
 tb/tb_xlink_rx_token_buffer.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/xlink_rx_token_buffer_if.sv
// Token-in / pop-out bundle between the XLINK receiver, the token buffer and the data processor.
// Master drives tokens and pop requests; slave is the buffer itself.
interface xlink_rx_token_buffer_if;
    logic [8:0] in_token;
    logic       in_valid;
    logic       rx_buf_en;
    logic [8:0] rx_buf_dout;
    logic       rx_buf_empty;

    modport master (
        output in_token,
        output in_valid,
        output rx_buf_en,
        input  rx_buf_dout,
        input  rx_buf_empty
    );

    modport slave (
        input  in_token,
        input  in_valid,
        input  rx_buf_en,
        output rx_buf_dout,
        output rx_buf_empty
    );
endinterface

// File: rtl/xlink_rx_token_buffer.sv
// Receive token FIFO: filters control tokens, buffers data tokens, and pops with one-cycle registered output.
// Tracks sticky overflow and a saturating count of dropped control tokens.
module xlink_rx_token_buffer #(
    parameter int DEPTH_LOG2 = 4,
    parameter bit DROP_CTRL  = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    xlink_rx_token_buffer_if.slave  rx,
    output logic [DEPTH_LOG2:0]     level,
    output logic                    overflow,
    input  logic                    ovf_clear,
    output logic [7:0]              ctrl_dropped
);
    localparam int                  DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LEVEL = DEPTH[DEPTH_LOG2:0];
    localparam logic [DEPTH_LOG2:0] LVL_ONE    = 1;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = 1;

    logic [8:0] mem [DEPTH];

    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    logic [8:0]            dout_q, dout_d;
    logic                  overflow_q, overflow_d;
    logic [7:0]            ctrl_dropped_q, ctrl_dropped_d;

    logic storable, drop_tok, empty, full, pop, wr;

    always_comb begin
        storable = rx.in_valid && (!rx.in_token[8] || !DROP_CTRL);
        drop_tok = rx.in_valid && rx.in_token[8] && DROP_CTRL;
        empty    = (level_q == '0);
        full     = (level_q == FULL_LEVEL);
        pop      = rx.rx_buf_en && !empty;
        // A pop in the same cycle frees the slot, so a full FIFO can still accept.
        wr       = storable && (!full || pop);

        wr_ptr_d = wr  ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        dout_d   = pop ? mem[rd_ptr_q] : dout_q;

        level_d = level_q;
        case ({wr, pop})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase

        // Clear first so a coincident new overflow wins.
        overflow_d = (overflow_q && !ovf_clear) || (storable && full && !pop);

        ctrl_dropped_d = ctrl_dropped_q;
        if (drop_tok && (ctrl_dropped_q != 8'hFF)) begin
            ctrl_dropped_d = ctrl_dropped_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            level_q        <= '0;
            dout_q         <= '0;
            overflow_q     <= 1'b0;
            ctrl_dropped_q <= '0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            level_q        <= level_d;
            dout_q         <= dout_d;
            overflow_q     <= overflow_d;
            ctrl_dropped_q <= ctrl_dropped_d;
        end
    end

    // Storage carries no reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wr_ptr_q] <= rx.in_token;
        end
    end

    assign rx.rx_buf_dout  = dout_q;
    assign rx.rx_buf_empty = (level_q == '0);
    assign level           = level_q;
    assign overflow        = overflow_q;
    assign ctrl_dropped    = ctrl_dropped_q;
endmodule

// File: tb/tb_xlink_rx_token_buffer.sv
// Directed + randomized bench for xlink_rx_token_buffer; two instances (control-drop on/off) share stimulus
// and are compared each cycle against queue-based reference models.
module tb_xlink_rx_token_buffer;
    localparam int DL    = 4;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic ovf_clear = 1'b0;
    always #5 clk = ~clk;

    xlink_rx_token_buffer_if bus0 ();
    xlink_rx_token_buffer_if bus1 ();

    logic [DL:0] level0, level1;
    logic        ovf0, ovf1;
    logic [7:0]  cd0, cd1;

    xlink_rx_token_buffer #(.DEPTH_LOG2(DL), .DROP_CTRL(1'b1)) dut_drop (
        .clk(clk), .reset(reset), .rx(bus0), .level(level0),
        .overflow(ovf0), .ovf_clear(ovf_clear), .ctrl_dropped(cd0)
    );

    xlink_rx_token_buffer #(.DEPTH_LOG2(DL), .DROP_CTRL(1'b0)) dut_keep (
        .clk(clk), .reset(reset), .rx(bus1), .level(level1),
        .overflow(ovf1), .ovf_clear(ovf_clear), .ctrl_dropped(cd1)
    );

    int tests = 0;
    int failed = 0;

    // Stimulus currently applied, and the reference models.
    logic [8:0] tok;
    logic       vld, en, clr;
    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic [8:0] dout0_m, dout1_m;
    bit         ovf0_m, ovf1_m;
    int         cd0_m, cd1_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic [8:0] t, input logic v, input logic e, input logic c);
        tok = t; vld = v; en = e; clr = c;
        bus0.in_token = t; bus0.in_valid = v; bus0.rx_buf_en = e;
        bus1.in_token = t; bus1.in_valid = v; bus1.rx_buf_en = e;
        ovf_clear = c;
    endtask

    task automatic model_reset();
        q0.delete(); q1.delete();
        dout0_m = '0; dout1_m = '0;
        ovf0_m = 0; ovf1_m = 0;
        cd0_m = 0; cd1_m = 0;
    endtask

    task automatic model_edge();
        int  n;
        bit  pop_ok;
        if (!reset) return;
        // Instance that drops control tokens.
        n = q0.size();
        pop_ok = en && (n > 0);
        if (clr) ovf0_m = 0;
        if (pop_ok) dout0_m = q0.pop_front();
        if (vld && !tok[8]) begin
            if (n < DEPTH || pop_ok) q0.push_back(tok);
            else ovf0_m = 1;
        end
        if (vld && tok[8] && cd0_m < 255) cd0_m++;
        // Instance that stores everything.
        n = q1.size();
        pop_ok = en && (n > 0);
        if (clr) ovf1_m = 0;
        if (pop_ok) dout1_m = q1.pop_front();
        if (vld) begin
            if (n < DEPTH || pop_ok) q1.push_back(tok);
            else ovf1_m = 1;
        end
    endtask

    task automatic check_all();
        chk("dout0",  32'(bus0.rx_buf_dout),  32'(dout0_m));
        chk("empty0", 32'(bus0.rx_buf_empty), 32'(q0.size() == 0));
        chk("level0", 32'(level0),            32'(q0.size()));
        chk("ovf0",   32'(ovf0),              32'(ovf0_m));
        chk("cdrop0", 32'(cd0),               32'(cd0_m));
        chk("dout1",  32'(bus1.rx_buf_dout),  32'(dout1_m));
        chk("empty1", 32'(bus1.rx_buf_empty), 32'(q1.size() == 0));
        chk("level1", 32'(level1),            32'(q1.size()));
        chk("ovf1",   32'(ovf1),              32'(ovf1_m));
        chk("cdrop1", 32'(cd1),               32'(0));
    endtask

    task automatic step(input logic [8:0] t, input logic v, input logic e, input logic c);
        set_in(t, v, e, c);
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        logic [8:0] fill_tok;
        set_in(9'h000, 1'b0, 1'b0, 1'b0);
        model_reset();
        #2;
        check_all();
        #10 reset = 1'b1;

        // Basic ordering.
        step(9'h012, 1, 0, 0);
        step(9'h034, 1, 0, 0);
        step(9'h056, 1, 0, 0);
        step(9'h078, 1, 0, 0);
        for (int i = 0; i < 4; i++) step(9'h000, 0, 1, 0);
        chk("basic_dout",  32'(bus0.rx_buf_dout), 32'h078);
        chk("basic_empty", 32'(bus0.rx_buf_empty), 32'd1);
        chk("basic_level", 32'(level0), 32'd0);

        // Control-token filtering.
        step(9'h0AA, 1, 0, 0);
        step(9'h101, 1, 0, 0);
        step(9'h1FF, 1, 0, 0);
        step(9'h0BB, 1, 0, 0);
        chk("ctrl_level_drop", 32'(level0), 32'd2);
        chk("ctrl_level_keep", 32'(level1), 32'd4);
        for (int i = 0; i < 4; i++) step(9'h000, 0, 1, 0);
        chk("ctrl_count", 32'(cd0), 32'd2);
        chk("ctrl_last_drop", 32'(bus0.rx_buf_dout), 32'h0BB);
        chk("ctrl_last_keep", 32'(bus1.rx_buf_dout), 32'h0BB);

        // Fill, overflow, drain, clear.
        for (int i = 0; i < 16; i++) step(9'(i), 1, 0, 0);
        step(9'h0EE, 1, 0, 0);
        chk("ovf_set",   32'(ovf0), 32'd1);
        chk("ovf_level", 32'(level0), 32'd16);
        for (int i = 0; i < 16; i++) begin
            step(9'h000, 0, 1, 0);
            chk("ovf_pop", 32'(bus0.rx_buf_dout), 32'(i));
        end
        chk("ovf_sticky", 32'(ovf0), 32'd1);
        step(9'h000, 0, 0, 1);
        chk("ovf_clear", 32'(ovf0), 32'd0);

        // Write + pop while full.
        for (int i = 0; i < 16; i++) begin
            fill_tok = {1'b0, 8'($urandom)};
            step(fill_tok, 1, 0, 0);
        end
        step(9'h0CC, 1, 1, 0);
        chk("full_wp_level", 32'(level0), 32'd16);
        chk("full_wp_ovf",   32'(ovf0), 32'd0);
        for (int i = 0; i < 16; i++) step(9'h000, 0, 1, 0);
        chk("full_wp_last", 32'(bus0.rx_buf_dout), 32'h0CC);

        // Pop while empty, then write + pop while empty.
        step(9'h000, 0, 1, 0);
        chk("empty_pop_dout",  32'(bus0.rx_buf_dout), 32'h0CC);
        chk("empty_pop_level", 32'(level0), 32'd0);
        step(9'h033, 1, 1, 0);
        chk("empty_wp_level", 32'(level0), 32'd1);
        chk("empty_wp_dout",  32'(bus0.rx_buf_dout), 32'h0CC);
        step(9'h000, 0, 1, 0);

        // Lagging pops force pointer wrap; async reset lands mid-stream.
        for (int i = 0; i < 43; i++) begin
            fill_tok = {1'b0, 8'($urandom)};
            step(fill_tok, i < 40, i >= 3, 0);
            if (i == 25) begin
                #2 reset = 1'b0;
                model_reset();
                #1;
                check_all();
                chk("rst_async_level", 32'(level0), 32'd0);
                @(posedge clk);
                #1;
                check_all();
                #2 reset = 1'b1;
            end
        end
        for (int i = 0; i < 4; i++) step(9'h000, 0, 1, 0);

        // Randomized traffic with varying fill/drain pressure.
        for (int blk = 0; blk < 8; blk++) begin
            int wp, rp;
            wp = $urandom_range(20, 90);
            rp = $urandom_range(20, 90);
            for (int i = 0; i < 50; i++) begin
                fill_tok = 9'($urandom);
                if ($urandom_range(0, 3) != 0) fill_tok[8] = 1'b0;
                step(fill_tok, $urandom_range(0, 99) < wp, $urandom_range(0, 99) < rp,
                     $urandom_range(0, 15) == 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
